// File: rtl/mult_pkg.sv
// Shared encodings for the sequential multiplier: FSM states and operation modes.
package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StCalc = ST_CALC,
    StDone = ST_DONE
  } mult_state_e;

endpackage

// File: rtl/mult_addsub_step.sv
// One multiplier iteration: conditional add/sub of the multiplicand into the
// accumulator, then a one-bit right shift of {acc, Q, q_m1}.
module mult_addsub_step
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             qm1_i,
  input  logic             mode_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] q_o,
  output logic             qm1_o
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;
  logic           shift_in;

  // Add/sub selection followed by the shift; unsigned shifts in zero, Booth sign-extends.
  always_comb begin
    m_ext    = (mode_i == MODE_SIGNED) ? {m_i[WIDTH-1], m_i} : {1'b0, m_i};
    sum      = acc_i;
    shift_in = 1'b0;
    if (mode_i == MODE_UNSIGNED) begin
      if (q_i[0]) begin
        sum = acc_i + m_ext;
      end
    end else begin
      unique case ({q_i[0], qm1_i})
        2'b01:   sum = acc_i + m_ext;
        2'b10:   sum = acc_i - m_ext;
        default: sum = acc_i;
      endcase
      shift_in = sum[WIDTH];
    end
    acc_o = {shift_in, sum[WIDTH:1]};
    q_o   = {sum[0], q_i[WIDTH-1:1]};
    qm1_o = q_i[0];
  end

endmodule

// File: rtl/seq_multiplier_param.sv
// Parametrised sequential multiplier with start/done handshake. Unsigned
// shift-add or signed Booth radix-2, one iteration per clock, WIDTH iterations.
module seq_multiplier_param
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               run_o,
  output logic               done_o
);

  mult_state_e        state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH:0]     acc_step;
  logic [WIDTH-1:0]   q_step;
  logic               qm1_step;

  mult_addsub_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i  (acc_q),
    .m_i    (m_q),
    .q_i    (q_q),
    .qm1_i  (qm1_q),
    .mode_i (mode_q),
    .acc_o  (acc_step),
    .q_o    (q_step),
    .qm1_o  (qm1_step)
  );

  // Next-state and datapath load/iterate decisions.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    prod_d  = prod_q;
    unique case (state_q)
      StIdle, StDone: begin
        // Product is left untouched on accept so the old result stays visible.
        if (start_i) begin
          m_d     = a_i;
          q_d     = b_i;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          mode_d  = mode_i;
          state_d = StCalc;
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        acc_d = acc_step;
        q_d   = q_step;
        qm1_d = qm1_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_W'(WIDTH)) begin
          prod_d  = {acc_step[WIDTH-1:0], q_step};
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_UNSIGNED;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      prod_q  <= prod_d;
    end
  end

  // Status decodes come straight from the state register.
  always_comb begin
    product_o = prod_q;
    run_o     = (state_q == StCalc);
    done_o    = (state_q == StDone);
  end

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Bench for seq_multiplier_param: a WIDTH=6 instance checked every cycle against
// an arithmetic model, plus a WIDTH=8 instance checked per operation.
module tb_seq_multiplier_param;

  localparam int W = 6;

  logic          clk;
  logic          rst_n;
  logic          start, mode;
  logic [W-1:0]  a, b;
  logic [2*W-1:0] product;
  logic          run, done;

  logic          start8, mode8;
  logic [7:0]    a8, b8;
  logic [15:0]   product8;
  logic          run8, done8;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  bit chk_en = 0;

  seq_multiplier_param #(
    .WIDTH (W)
  ) u_dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .mode_i    (mode),
    .a_i       (a),
    .b_i       (b),
    .product_o (product),
    .run_o     (run),
    .done_o    (done)
  );

  seq_multiplier_param #(
    .WIDTH (8)
  ) u_dut8 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start8),
    .mode_i    (mode8),
    .a_i       (a8),
    .b_i       (b8),
    .product_o (product8),
    .run_o     (run8),
    .done_o    (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact product truncated to 2*w bits; signed operands are sign-interpreted.
  function automatic longint ref_mul(input int w, input bit m, input longint x, input longint y);
    longint mask;
    mask = (longint'(1) << (2 * w)) - 1;
    if (m) begin
      if (x[w-1]) x = x - (longint'(1) << w);
      if (y[w-1]) y = y - (longint'(1) << w);
    end
    return (x * y) & mask;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshake-level model: an accept starts a W-cycle busy window, then one done cycle.
  int             m_left;
  bit             m_done;
  logic [2*W-1:0] m_prod, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_prod <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_prod <= m_pend;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_left <= W;
        m_pend <= (2*W)'(ref_mul(W, mode, longint'(a), longint'(b)));
      end
    end
  end

  // Per-cycle comparison of the WIDTH=6 instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (run !== (m_left > 0) || done !== m_done || product !== m_prod) begin
        bad++;
        $display("FAIL cycle@%0t: run=%b done=%b prod=%h expected run=%b done=%b prod=%h",
                 $time, run, done, product, (m_left > 0), m_done, m_prod);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  // Wait from the current negedge for done; counts run cycles seen on the way.
  task automatic wait_done(input string name, output int runs, output bit got);
    runs = 0;
    got  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (run === 1'b1) runs++;
      @(negedge clk);
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: done not seen, expected within 30 cycles", name);
    end
  endtask

  task automatic op6(input string name, input bit m, input logic [W-1:0] x,
                     input logic [W-1:0] y, input bit use_lit, input logic [2*W-1:0] lit);
    int runs;
    bit got;
    @(negedge clk);
    start = 1'b1; mode = m; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    wait_done(name, runs, got);
    if (got) begin
      if (use_lit) check({name, "_prod"}, 64'(product), 64'(lit));
      check({name, "_runs"}, 64'(runs), 64'(W));
    end
  endtask

  task automatic op8(input string name, input bit m, input logic [7:0] x, input logic [7:0] y);
    bit got;
    longint exp;
    exp = ref_mul(8, m, longint'(x), longint'(y));
    @(negedge clk);
    start8 = 1'b1; mode8 = m; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done8 === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: done not seen, expected within 30 cycles", name);
    end else begin
      check(name, 64'(product8), 64'(exp));
    end
  endtask

  initial begin
    int runs;
    bit got;
    int d0;
    rst_n = 1'b0;
    start = 1'b0; mode = 1'b0; a = '0; b = '0;
    start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_prod", 64'(product), 64'd0);
    check("reset_run", 64'(run), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned shift-add.
    op6("u_33x33", 1'b0, 6'b100001, 6'b100001, 1'b1, 12'b010001000001);
    op6("u_63x63", 1'b0, 6'b111111, 6'b111111, 1'b1, 12'b111110000001);

    // Signed Booth, including the most-negative squared case.
    op6("s_m32xm32", 1'b1, 6'b100000, 6'b100000, 1'b1, 12'b010000000000);
    op6("s_m32x31", 1'b1, 6'b100000, 6'b011111, 1'b1, 12'b110000100000);
    op6("s_m1xm1", 1'b1, 6'b111111, 6'b111111, 1'b1, 12'b000000000001);

    // Start held through CALC with wandering operands, then back-to-back from DONE.
    @(negedge clk);
    d0 = done_cnt;
    start = 1'b1; mode = 1'b0; a = 6'd5; b = 6'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = W'($urandom);
      b = W'($urandom);
    end
    start = 1'b0;
    wait_done("hold", runs, got);
    if (got) check("hold_prod", 64'(product), 64'd35);
    start = 1'b1; mode = 1'b0; a = 6'd9; b = 6'd11;
    @(negedge clk);
    start = 1'b0;
    check("b2b_old_prod", 64'(product), 64'd35);
    wait_done("b2b", runs, got);
    if (got) check("b2b_prod", 64'(product), 64'd99);
    @(negedge clk);
    check("b2b_done_pulses", 64'(done_cnt - d0), 64'd2);

    // Reset during iteration 3 aborts at once.
    start = 1'b1; mode = 1'b0; a = 6'd13; b = 6'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_run", 64'(run), 64'd0);
    check("abort_prod", 64'(product), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op6("after_reset", 1'b1, 6'b110000, 6'd3, 1'b1, 12'hFD0);

    // Product holds while idle; zero operand still runs all iterations.
    repeat (5) @(negedge clk);
    check("idle_hold", 64'(product), 64'hFD0);
    op6("zero_a", 1'b0, 6'b000000, 6'b100001, 1'b1, 12'h000);

    // Random operations on the 6-bit unit, checked by the per-cycle model.
    for (int i = 0; i < 100; i++) begin
      op6("rand6", 1'($urandom), W'($urandom), W'($urandom), 1'b0, '0);
    end

    // 8-bit build.
    op8("w8_u_ffxff", 1'b0, 8'hFF, 8'hFF);
    check("w8_u_ffxff_lit", 64'(product8), 64'hFE01);
    op8("w8_s_80x80", 1'b1, 8'h80, 8'h80);
    check("w8_s_80x80_lit", 64'(product8), 64'h4000);
    for (int i = 0; i < 1000; i++) begin
      op8("w8_rand", 1'(i & 1), 8'($urandom), 8'($urandom));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
